// File: rtl/sync_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_buf
// Purpose  : Single-clock FIFO with register-array storage. It provides the
//            FIFO side of the write_en/full and read_en/empty handshake used
//            between convolution pipeline stages. It also provides an
//            occupancy count, programmable almost-full and almost-empty flags,
//            a synchronous flush, and a selectable standard or
//            first-word-fall-through (FWFT) read mode.
// Ports    : clk, rst (async, active-high), flush
//            write_en / write_data             -> push side
//            read_en / read_data               -> pop side
//            full, empty, almost_full, almost_empty, count -> status (registered)
//            overflow, underflow, err_clr      -> sticky error flags
// Config   : macro FIFO_ERR_FLAGS_EN enables the sticky overflow/underflow
//            flags. When it is not defined, both flags are tied to 0 and
//            err_clr is ignored.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_buf #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
   parameter int AE_LEVEL   = 1,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  write_en,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read_en,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam logic [ADDR_WIDTH:0] c_depth    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] c_af_level = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] c_ae_level = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

   logic [ADDR_WIDTH:0] r_wr_ptr;
   logic [ADDR_WIDTH:0] r_rd_ptr;
   logic [ADDR_WIDTH:0] r_count;
   logic                r_full;
   logic                r_empty;
   logic                r_almost_full;
   logic                r_almost_empty;

   logic                w_do_wr;
   logic                w_do_rd;
   logic [ADDR_WIDTH:0] w_wr_ptr_nxt;
   logic [ADDR_WIDTH:0] w_rd_ptr_nxt;
   logic [ADDR_WIDTH:0] w_count_nxt;

   // Acceptance uses only the registered flags, so a pop cannot make room
   // for a push in the same cycle. Flush suppresses both operations.
   assign w_do_wr = write_en & ~r_full  & ~flush;
   assign w_do_rd = read_en  & ~r_empty & ~flush;

   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      if (flush) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
      end else begin
         if (w_do_wr) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
         if (w_do_rd) w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      end
   end

   // The pointers carry one extra MSB, so their modular difference gives
   // the range 0..DEPTH without ambiguity.
   assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         r_wr_ptr       <= w_wr_ptr_nxt;
         r_rd_ptr       <= w_rd_ptr_nxt;
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == c_depth);
         r_empty        <= (w_count_nxt == '0);
         r_almost_full  <= (w_count_nxt >= c_af_level);
         r_almost_empty <= (w_count_nxt <= c_ae_level);
      end
   end

   // Storage is deliberately left unreset; occupancy tracking alone defines
   // which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= write_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // The head word is always visible. It is meaningless while empty.
         assign read_data = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_read_data;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)          r_read_data <= '0;
            else if (w_do_rd) r_read_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
         end
         assign read_data = r_read_data;
      end
   endgenerate

`ifdef FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // Flush does not affect these flags. A clear takes priority over a set
   // in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (err_clr) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (write_en && r_full)  r_overflow  <= 1'b1;
         if (read_en  && r_empty) r_underflow <= 1'b1;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign overflow         = 1'b0;
   assign underflow        = 1'b0;
`endif

   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_buf
// Purpose  : Directed, table-driven bench for sync_fifo_buf.
//            - u_std uses the standard read mode (DEPTH 4, AF 3, AE 1).
//            - u_fwft uses the same geometry in FWFT mode.
//            Each expected value is computed by hand and listed in the table.
//            The expected overflow and underflow values assume the error
//            flags are enabled. They are masked to 0 when FIFO_ERR_FLAGS_EN
//            is not defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_buf;

`ifdef FIFO_ERR_FLAGS_EN
   localparam logic c_err_en = 1'b1;
`else
   localparam logic c_err_en = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0, write_en = 1'b0, read_en = 1'b0, err_clr = 1'b0;
   logic [7:0] write_data = '0;
   logic [7:0] read_data;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [2:0] count;

   logic       f_flush = 1'b0, f_we = 1'b0, f_re = 1'b0, f_ec = 1'b0;
   logic [7:0] f_wd = '0;
   logic [7:0] f_rd;
   logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
   logic [2:0] f_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .write_data(write_data),
      .read_en(read_en), .read_data(read_data), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr));

   sync_fifo_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .flush(f_flush), .write_en(f_we), .write_data(f_wd),
      .read_en(f_re), .read_data(f_rd), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ov), .underflow(f_un), .err_clr(f_ec));

   typedef struct {
      logic       fl, we, re, ec;
      logic [7:0] wd;
      logic [7:0] rd;
      logic [2:0] cnt;
      logic       e, f, af, ae, ov, un;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic fl, input logic we, input logic [7:0] wd, input logic re,
                      input logic ec, input logic [7:0] rd, input logic [2:0] cnt,
                      input logic e, input logic f, input logic af, input logic ae,
                      input logic ov, input logic un);
      vec_t v;
      v.fl = fl; v.we = we; v.wd = wd; v.re = re; v.ec = ec;
      v.rd = rd; v.cnt = cnt; v.e = e; v.f = f; v.af = af; v.ae = ae; v.ov = ov; v.un = un;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_std(input string tag, input logic [7:0] rd, input logic [2:0] cnt,
                            input logic e, input logic f, input logic af, input logic ae,
                            input logic ov, input logic un);
      check({tag, " read_data"}, 32'(read_data), 32'(rd));
      check({tag, " count"}, 32'(count), 32'(cnt));
      check({tag, " empty"}, 32'(empty), 32'(e));
      check({tag, " full"}, 32'(full), 32'(f));
      check({tag, " almost_full"}, 32'(almost_full), 32'(af));
      check({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
      check({tag, " overflow"}, 32'(overflow), 32'(ov & c_err_en));
      check({tag, " underflow"}, 32'(underflow), 32'(un & c_err_en));
   endtask

   // Inputs settle before the rising edge. Outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Columns: fl we wd re ec | rd cnt e f af ae ov un
      // Fill to full, then attempt one write too many.
      add(0,1,8'h11,0,0, 8'h00,3'd1,0,0,0,1,0,0);
      add(0,1,8'h22,0,0, 8'h00,3'd2,0,0,0,0,0,0);
      add(0,1,8'h33,0,0, 8'h00,3'd3,0,0,1,0,0,0);
      add(0,1,8'h44,0,0, 8'h00,3'd4,0,1,1,0,0,0);
      add(0,1,8'h55,0,0, 8'h00,3'd4,0,1,1,0,1,0);
      // Drain in order.
      add(0,0,8'h00,1,0, 8'h11,3'd3,0,0,1,0,1,0);
      add(0,0,8'h00,1,0, 8'h22,3'd2,0,0,0,0,1,0);
      add(0,0,8'h00,1,0, 8'h33,3'd1,0,0,0,1,1,0);
      add(0,0,8'h00,1,0, 8'h44,3'd0,1,0,0,1,1,0);
      add(0,0,8'h00,0,1, 8'h44,3'd0,1,0,0,1,0,0);
      // Wrap: six write/read rounds; the pointers pass both index and MSB wrap.
      for (int i = 0; i < 6; i++) begin
         add(0,1,8'hA0 + 8'(i),0,0, (i == 0) ? 8'h44 : 8'hA0 + 8'(i-1),3'd1,0,0,0,1,0,0);
         add(0,0,8'h00,1,0, 8'hA0 + 8'(i),3'd0,1,0,0,1,0,0);
      end
      // Full with read+write: the read is taken and the write dropped.
      add(0,1,8'h01,0,0, 8'hA5,3'd1,0,0,0,1,0,0);
      add(0,1,8'h02,0,0, 8'hA5,3'd2,0,0,0,0,0,0);
      add(0,1,8'h03,0,0, 8'hA5,3'd3,0,0,1,0,0,0);
      add(0,1,8'h04,0,0, 8'hA5,3'd4,0,1,1,0,0,0);
      add(0,1,8'h99,1,0, 8'h01,3'd3,0,0,1,0,1,0);
      add(0,0,8'h00,0,1, 8'h01,3'd3,0,0,1,0,0,0);
      add(0,0,8'h00,1,0, 8'h02,3'd2,0,0,0,0,0,0);
      add(0,0,8'h00,1,0, 8'h03,3'd1,0,0,0,1,0,0);
      add(0,0,8'h00,1,0, 8'h04,3'd0,1,0,0,1,0,0);
      // Empty with read+write: the write is taken and the read dropped.
      add(0,1,8'h77,1,0, 8'h04,3'd1,0,0,0,1,0,1);
      add(0,0,8'h00,1,0, 8'h77,3'd0,1,0,0,1,0,1);
      add(0,0,8'h00,0,1, 8'h77,3'd0,1,0,0,1,0,0);
      // Flush with three words stored and write_en active.
      add(0,1,8'hB1,0,0, 8'h77,3'd1,0,0,0,1,0,0);
      add(0,1,8'hB2,0,0, 8'h77,3'd2,0,0,0,0,0,0);
      add(0,1,8'hB3,0,0, 8'h77,3'd3,0,0,1,0,0,0);
      add(1,1,8'hBB,1,0, 8'h77,3'd0,1,0,0,1,0,0);
      add(0,1,8'hC1,0,0, 8'h77,3'd1,0,0,0,1,0,0);
      add(0,0,8'h00,1,0, 8'hC1,3'd0,1,0,0,1,0,0);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_std("reset", 8'h00, 3'd0, 1, 0, 0, 1, 0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         flush = vecs[i].fl; write_en = vecs[i].we; write_data = vecs[i].wd;
         read_en = vecs[i].re; err_clr = vecs[i].ec;
         step();
         check_std($sformatf("vec%0d", i), vecs[i].rd, vecs[i].cnt, vecs[i].e, vecs[i].f,
                   vecs[i].af, vecs[i].ae, vecs[i].ov, vecs[i].un);
      end
      flush = 0; write_en = 0; read_en = 0; err_clr = 0;

      // Assert reset asynchronously in the middle of a write burst.
      write_en = 1; write_data = 8'hD0; step();
      write_data = 8'hD1; step();
      write_data = 8'hD2; read_en = 1; step();
      read_en = 0;
      #2 rst = 1'b1;
      #1 check_std("async_rst", 8'h00, 3'd0, 1, 0, 0, 1, 0, 0);
      write_en = 0;
      @(posedge clk); #1 rst = 1'b0;
      write_en = 1; write_data = 8'hE1; step();
      write_en = 0; read_en = 1; step();
      read_en = 0;
      check_std("post_rst_read", 8'hE1, 3'd0, 1, 0, 0, 1, 0, 0);

      // FWFT mode: the head word is visible without read_en.
      check("fwft idle empty", 32'(f_empty), 32'd1);
      f_we = 1; f_wd = 8'h5A; step();
      check("fwft empty after write", 32'(f_empty), 32'd0);
      check("fwft head", 32'(f_rd), 32'h5A);
      f_wd = 8'h6B; step();
      f_we = 0;
      check("fwft head holds", 32'(f_rd), 32'h5A);
      check("fwft count", 32'(f_count), 32'd2);
      f_re = 1; step();
      check("fwft pop to next", 32'(f_rd), 32'h6B);
      step();
      f_re = 0;
      check("fwft empty after pops", 32'(f_empty), 32'd1);
      check("fwft count zero", 32'(f_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
